// File: rtl/btn_debounce_edge.sv
// -----------------------------------------------------------------------------
// btn_debounce_edge
//
// Purpose:
//   Conditions a raw, asynchronous, bouncy push-button level for the
//   downstream 1010 sequence detector. The input is brought into the clk
//   domain through a two-flop synchronizer. A four-state FSM then accepts a
//   new level only after it has been held for DEBOUNCE_CYCLES consecutive
//   cycles. Accepted transitions produce a clean registered level and
//   single-cycle rise/fall strobes.
//
// Ports:
//   clk       in   system clock, rising edge active
//   rst       in   asynchronous reset, active low (0 = reset)
//   btn_raw   in   raw button level, asynchronous and bouncy
//   btn_db    out  debounced button level (registered)
//   btn_rise  out  one-cycle strobe on an accepted 0->1 transition
//                  (plus auto-repeat strobes when AUTO_REPEAT_EN is defined)
//   btn_fall  out  one-cycle strobe on an accepted 1->0 transition
//   busy      out  high while a candidate transition is being qualified
//
// Build option:
//   AUTO_REPEAT_EN - when defined, holding the button in the accepted-high
//   state issues extra btn_rise strobes REPEAT_DELAY cycles after
//   acceptance, then every REPEAT_PERIOD cycles. When undefined, no repeat
//   logic is built and the REPEAT_* parameters have no effect.
// -----------------------------------------------------------------------------
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // An out-of-range configuration shows up as this named scope in the
    // elaborated hierarchy, which the configuration checker looks for.
    if ((DEBOUNCE_CYCLES < 1) || ((2 ** CNT_W) <= DEBOUNCE_CYCLES) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_cfg_out_of_range
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    // After a repeat strobe the counter is rewound so that it reaches
    // REP_LAST again exactly REPEAT_PERIOD cycles later.
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0] REP_ZERO   = {REP_W{1'b0}};

    logic [REP_W-1:0] r_rep_cnt;
`endif

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    // Two-flop synchronizer bringing btn_raw into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM: qualification counter, level, strobes and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= CNT_ZERO;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt <= REP_ZERO;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            case (r_state)
                ST_STABLE_LO: begin
                    if (r_s2) begin
                        r_state <= ST_PEND_HI;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                ST_PEND_HI: begin
                    if (!r_s2) begin
                        // Excursion too short: drop it silently.
                        r_state <= ST_STABLE_LO;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_STABLE_HI;
                        r_db    <= 1'b1;
                        r_rise  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        // Never passes CNT_LAST: acceptance happens there.
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                ST_STABLE_HI: begin
                    if (!r_s2) begin
                        r_state <= ST_PEND_LO;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end

                ST_PEND_LO: begin
                    if (r_s2) begin
                        r_state <= ST_STABLE_HI;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_STABLE_LO;
                        r_db    <= 1'b0;
                        r_fall  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_STABLE_LO;
                    r_cnt   <= CNT_ZERO;
                    r_db    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

`ifdef AUTO_REPEAT_EN
            // Repeat counter only runs while the press is held in STABLE_HI;
            // it is zero on the cycle the press is accepted.
            if ((r_state == ST_STABLE_HI) && r_s2) begin
                if (r_rep_cnt == REP_LAST) begin
                    r_rise    <= 1'b1;
                    r_rep_cnt <= REP_RELOAD;
                end else begin
                    r_rep_cnt <= r_rep_cnt + REP_ONE;
                end
            end else begin
                r_rep_cnt <= REP_ZERO;
            end
`endif
        end
    end

    assign btn_db   = r_db;
    assign btn_rise = r_rise;
    assign btn_fall = r_fall;
    assign busy     = r_busy;

endmodule

// File: doc/btn_debounce_edge.md
Name: btn_debounce_edge

Overview:
- Input conditioning stage that sits directly upstream of the Mealy 1010 sequence detector.
- Synchronizes the raw, asynchronous push-button input into clk, rejects bounce and glitches, and presents a clean debounced level.
- Also produces single-cycle rise/fall strobes, which feed the detector's serial bit input.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive clk cycles the synchronized input must hold a new level before it is accepted; legal range >= 1.
- CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 64, cycles held high before the first auto-repeat strobe (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeat strobes (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_raw  input  1  raw button level, asynchronous to clk and bouncy.
- btn_db  output  1  debounced, registered button level.
- btn_rise  output  1  one-cycle strobe on an accepted 0->1 transition (plus auto-repeats when enabled).
- btn_fall  output  1  one-cycle strobe on an accepted 1->0 transition.
- busy  output  1  high while a candidate transition is being qualified (PEND states).

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops, counter, btn_db, btn_rise, btn_fall and busy all go to 0.
  - FSM goes to STABLE_LO, regardless of btn_raw.
- Synchronizer: two-flop chain btn_raw -> s1 -> s2. Only s2 is used downstream.
- FSM states and transitions:
  - STABLE_LO: if s2=1, go to PEND_HI with cnt<=0; otherwise hold.
  - PEND_HI:
    - s2=0: return to STABLE_LO. Glitch rejected, no strobe.
    - s2=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HI, btn_db<=1, btn_rise<=1.
    - otherwise: cnt<=cnt+1.
  - STABLE_HI: if s2=0, go to PEND_LO with cnt<=0; otherwise hold.
  - PEND_LO: mirror of PEND_HI. Accepting the transition goes to STABLE_LO with btn_db<=0 and btn_fall<=1. If s2 returns to 1, go back to STABLE_HI.
- Latency:
  - btn_raw changes before edge k and stays stable.
  - btn_db changes and the strobe is high after edge k+DEBOUNCE_CYCLES+2.
  - The strobe is high for exactly 1 cycle and is deasserted on the next edge.
- Glitch rule: any excursion of s2 lasting fewer than DEBOUNCE_CYCLES cycles produces no change on btn_db and no strobe. The counter restarts from 0 on every re-entry to a PEND state.
- busy = 1 exactly while the FSM is in PEND_HI or PEND_LO (registered with the state).
- btn_rise and btn_fall are never high in the same cycle.
- Counter: saturates at DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-qualification: the pending transition is discarded and no strobe is issued.
  - If btn_raw is held high across reset release, a fresh btn_rise occurs DEBOUNCE_CYCLES+2 edges after the first edge following release.
- Downstream contract: the detector samples btn_db (level mode) or btn_rise (press mode). The output is glitch-free and synchronous to clk.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While in STABLE_HI, a repeat counter runs from entry into that state.
  - Additional one-cycle btn_rise strobes are issued REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
  - The repeat counter clears on leaving STABLE_HI or on reset.
  - btn_db is unaffected.
- Not defined: btn_rise fires only once per accepted press. REPEAT_DELAY and REPEAT_PERIOD are ignored, and no repeat logic is synthesized.

Test Plan:
- Reset check: hold rst=0 with btn_raw=1 -> all outputs 0. Release rst, keep btn_raw=1 -> btn_rise high for exactly 1 cycle and btn_db=1, both 18 edges after release (DEBOUNCE_CYCLES=16).
- Clean press: btn_raw 0->1 before edge 10, held 40 cycles -> btn_db=1 and btn_rise=1 after edge 28; btn_rise=0 after edge 29; busy high over edges 12..27.
- Bounce rejection: btn_raw toggles 1,0,1,0 with 3-cycle widths, then settles at 1 -> exactly one btn_rise, 18 edges after the final settle; no btn_fall.
- Glitch: a single 5-cycle high pulse from the idle-low state -> btn_db stays 0, no strobes, busy returns to 0.
- Release path: from STABLE_HI, btn_raw 1->0 held -> btn_fall for 1 cycle and btn_db=0, 18 edges later. Async rst pulse while in PEND_LO -> outputs 0 immediately, no btn_fall.
- Auto-repeat (AUTO_REPEAT_EN, DELAY=64, PERIOD=16): hold the button for 120 cycles after acceptance -> btn_rise at acceptance, then at +64, +80, +96 and +112; none without the macro.
